// File: rtl/limbus_sysid_pkg.sv
`default_nettype none
// ============================================================================
// Module      : limbus_sysid_pkg
// Description : Register map and field constants shared by the limbus
//               system-identification peripheral.
// Revision    : 1.0 - initial release
// ============================================================================
package limbus_sysid_pkg;

    localparam logic [3:0] c_ADDR_ID        = 4'd0;
    localparam logic [3:0] c_ADDR_TIMESTAMP = 4'd1;
    localparam logic [3:0] c_ADDR_CAPS      = 4'd2;
    localparam logic [3:0] c_ADDR_SCRATCH   = 4'd3;
    localparam logic [3:0] c_ADDR_UPTIME_LO = 4'd4;
    localparam logic [3:0] c_ADDR_UPTIME_HI = 4'd5;
    localparam logic [3:0] c_ADDR_STATUS    = 4'd6;
    localparam logic [3:0] c_ADDR_RSVD      = 4'd7;
    localparam logic [3:0] c_ADDR_USER_BASE = 4'd8;

    localparam logic [15:0] c_CAPS_MAGIC = 16'h5359;

    localparam int c_STATUS_ERR_BIT = 0;

endpackage : limbus_sysid_pkg
`default_nettype wire

// File: rtl/limbus_uptime_ctr.sv
`default_nettype none
// ============================================================================
// Module      : limbus_uptime_ctr
// Description : Prescaled free-running uptime counter with a high-word shadow
//               captured on snapshot, so a LO/HI read pair is coherent.
// Revision    : 1.0 - initial release
// ============================================================================
module limbus_uptime_ctr #(
    parameter int UPTIME_W = 48,
    parameter int TICK_DIV = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_snapshot,
    output logic [31:0] o_uptime_lo,
    output logic [31:0] o_shadow
);

    localparam int                 c_PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_PRE_W-1:0] c_PRE_LAST = c_PRE_W'(TICK_DIV - 1);

    logic [c_PRE_W-1:0]  r_pre_q,    w_pre_d;
    logic [UPTIME_W-1:0] r_uptime_q, w_uptime_d;
    logic [31:0]         r_shadow_q, w_shadow_d;
    logic                w_tick;

    always_comb begin
        w_tick     = (r_pre_q == c_PRE_LAST);
        w_pre_d    = w_tick ? '0 : r_pre_q + c_PRE_W'(1);
        w_uptime_d = w_tick ? r_uptime_q + UPTIME_W'(1) : r_uptime_q;
        // Shadow captures the upper bits on the same edge the LO word is sampled.
        w_shadow_d = i_snapshot ? 32'(r_uptime_q >> 32) : r_shadow_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre_q    <= '0;
            r_uptime_q <= '0;
            r_shadow_q <= '0;
        end else begin
            r_pre_q    <= w_pre_d;
            r_uptime_q <= w_uptime_d;
            r_shadow_q <= w_shadow_d;
        end
    end

    assign o_uptime_lo = r_uptime_q[31:0];
    assign o_shadow    = r_shadow_q;

endmodule : limbus_uptime_ctr
`default_nettype wire

// File: rtl/limbus_sysid_ext.sv
`default_nettype none
// ============================================================================
// Module      : limbus_sysid_ext
// Description : Avalon-MM system-ID peripheral: ID, timestamp, capabilities,
//               scratch, coherent uptime, error status and user words.
// Revision    : 1.0 - initial release
// ============================================================================
module limbus_sysid_ext
    import limbus_sysid_pkg::*;
#(
    parameter logic [31:0] ID_VALUE       = 32'h0000_0000,
    parameter logic [31:0] TIMESTAMP      = 32'd1415705966,
    parameter int          NUM_USER_WORDS = 4,
    parameter logic [32*((NUM_USER_WORDS > 0) ? NUM_USER_WORDS : 1)-1:0] USER_WORDS = '0,
    parameter int          UPTIME_W       = 48,
    parameter int          TICK_DIV       = 1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [3:0]  address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        readdatavalid
);

    if (NUM_USER_WORDS > 8 || UPTIME_W < 33 || UPTIME_W > 64 || TICK_DIV < 1) begin : g_bad_params
        $error("limbus_sysid_ext: illegal parameter combination");
    end

    localparam logic [31:0] c_CAPS = {c_CAPS_MAGIC, 8'(UPTIME_W), 8'(NUM_USER_WORDS)};

    logic [31:0] w_user [8];

    for (genvar k = 0; k < 8; k++) begin : g_user
        if (k < NUM_USER_WORDS) begin : g_used
            assign w_user[k] = USER_WORDS[32*k +: 32];
        end else begin : g_unused
            assign w_user[k] = '0;
        end
    end

    logic [31:0] r_readdata_q, w_readdata_d;
    logic        r_rdv_q,      w_rdv_d;
    logic [31:0] r_scratch_q,  w_scratch_d;
    logic        r_err_q,      w_err_d;

    logic        w_rd_ok, w_wr_ok, w_collide;
    logic        w_wr_scratch, w_wr_status;
    logic        w_err_set, w_err_clr, w_snapshot;
    logic [31:0] w_rdata, w_status, w_uptime_lo, w_shadow;

    limbus_uptime_ctr #(
        .UPTIME_W (UPTIME_W),
        .TICK_DIV (TICK_DIV)
    ) u_uptime (
        .clk         (clock),
        .rst_n       (reset_n),
        .i_snapshot  (w_snapshot),
        .o_uptime_lo (w_uptime_lo),
        .o_shadow    (w_shadow)
    );

    always_comb begin
        // A read colliding with a write performs neither access.
        w_collide    = read & write;
        w_rd_ok      = read & ~write;
        w_wr_ok      = write & ~read;
        w_snapshot   = w_rd_ok && (address == c_ADDR_UPTIME_LO);
        w_wr_scratch = w_wr_ok && (address == c_ADDR_SCRATCH);
        w_wr_status  = w_wr_ok && (address == c_ADDR_STATUS);
        w_err_set    = w_collide | (w_wr_ok & ~w_wr_scratch & ~w_wr_status);
        w_err_clr    = w_wr_status & writedata[c_STATUS_ERR_BIT];

        w_status                   = '0;
        w_status[c_STATUS_ERR_BIT] = r_err_q;

        case (address)
            c_ADDR_ID:        w_rdata = ID_VALUE;
            c_ADDR_TIMESTAMP: w_rdata = TIMESTAMP;
            c_ADDR_CAPS:      w_rdata = c_CAPS;
            c_ADDR_SCRATCH:   w_rdata = r_scratch_q;
            c_ADDR_UPTIME_LO: w_rdata = w_uptime_lo;
            c_ADDR_UPTIME_HI: w_rdata = w_shadow;
            c_ADDR_STATUS:    w_rdata = w_status;
            c_ADDR_RSVD:      w_rdata = '0;
            default:          w_rdata = (address >= c_ADDR_USER_BASE) ? w_user[address[2:0]] : '0;
        endcase

        w_rdv_d      = w_rd_ok;
        w_readdata_d = w_rd_ok ? w_rdata : r_readdata_q;
        w_scratch_d  = w_wr_scratch ? writedata : r_scratch_q;
        // Set takes priority over a clear landing on the same edge.
        w_err_d      = w_err_set ? 1'b1 : (w_err_clr ? 1'b0 : r_err_q);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_readdata_q <= '0;
            r_rdv_q      <= 1'b0;
            r_scratch_q  <= '0;
            r_err_q      <= 1'b0;
        end else begin
            r_readdata_q <= w_readdata_d;
            r_rdv_q      <= w_rdv_d;
            r_scratch_q  <= w_scratch_d;
            r_err_q      <= w_err_d;
        end
    end

    assign readdata      = r_readdata_q;
    assign readdatavalid = r_rdv_q;

endmodule : limbus_sysid_ext
`default_nettype wire

// File: tb/tb_limbus_sysid_ext.sv
`default_nettype none
// ============================================================================
// Module      : tb_limbus_sysid_ext
// Description : Directed self-checking bench for limbus_sysid_ext.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_limbus_sysid_ext;

    localparam logic [31:0] c_ID   = 32'hC0DE_1D01;
    localparam logic [31:0] c_TS   = 32'd1415705966;
    localparam logic [31:0] c_CAPS = 32'h5359_3004;
    localparam logic [127:0] c_USER = {32'h4444_0003, 32'h3333_0002,
                                       32'h2222_0001, 32'h1111_0000};

    logic        clock;
    logic        reset_n;
    logic [3:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        readdatavalid;

    int checks   = 0;
    int failures = 0;

    limbus_sysid_ext #(
        .ID_VALUE       (c_ID),
        .TIMESTAMP      (c_TS),
        .NUM_USER_WORDS (4),
        .USER_WORDS     (c_USER),
        .UPTIME_W       (48),
        .TICK_DIV       (1)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .address       (address),
        .read          (read),
        .write         (write),
        .writedata     (writedata),
        .readdata      (readdata),
        .readdatavalid (readdatavalid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [3:0] a, input logic [31:0] exp, input string tag);
        @(negedge clock);
        address = a;
        read    = 1'b1;
        @(negedge clock);
        read = 1'b0;
        chk({tag, "_rdv"}, {31'b0, readdatavalid}, 32'd1);
        chk(tag, readdata, exp);
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d, input string tag);
        @(negedge clock);
        address   = a;
        writedata = d;
        write     = 1'b1;
        @(negedge clock);
        write = 1'b0;
        chk({tag, "_no_rdv"}, {31'b0, readdatavalid}, 32'd0);
    endtask

    function automatic logic [31:0] exp_map(input int a);
        logic [127:0] u;
        u = c_USER;
        case (a)
            0:       return c_ID;
            1:       return c_TS;
            2:       return c_CAPS;
            3:       return 32'h1357_9BDF;
            5:       return 32'd1;
            6:       return 32'd1;
            8:       return u[31:0];
            9:       return u[63:32];
            10:      return u[95:64];
            11:      return u[127:96];
            default: return 32'd0;
        endcase
    endfunction

    initial begin
        reset_n   = 1'b0;
        address   = '0;
        read      = 1'b0;
        write     = 1'b0;
        writedata = '0;
        repeat (3) @(negedge clock);
        chk("reset_rdv", {31'b0, readdatavalid}, 32'd0);
        chk("reset_readdata", readdata, 32'd0);
        reset_n = 1'b1;

        rd(4'd0, c_ID, "read_id");
        rd(4'd1, c_TS, "read_timestamp");
        rd(4'd2, c_CAPS, "read_caps");
        @(negedge clock);
        chk("hold_rdv_low", {31'b0, readdatavalid}, 32'd0);
        chk("hold_readdata", readdata, c_CAPS);

        wr(4'd3, 32'hA5A5_5A5A, "write_scratch");
        rd(4'd3, 32'hA5A5_5A5A, "read_scratch");

        // Reset lands between the read strobe and its sampling edge.
        @(negedge clock);
        address = 4'd3;
        read    = 1'b1;
        #2 reset_n = 1'b0;
        @(negedge clock);
        read = 1'b0;
        chk("abort_rdv", {31'b0, readdatavalid}, 32'd0);
        chk("abort_readdata", readdata, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("post_reset_no_rdv", {31'b0, readdatavalid}, 32'd0);
        end
        rd(4'd3, 32'd0, "scratch_after_reset");

        // Pin the counter just below a 32-bit carry and snapshot it.
        @(negedge clock);
        force dut.u_uptime.r_uptime_q = 48'h0000_FFFF_FFFE;
        address = 4'd4;
        read    = 1'b1;
        @(posedge clock);
        #1 release dut.u_uptime.r_uptime_q;
        @(negedge clock);
        read = 1'b0;
        chk("uptime_lo_rdv", {31'b0, readdatavalid}, 32'd1);
        chk("uptime_lo_pinned", readdata, 32'hFFFF_FFFE);
        repeat (5) @(negedge clock);
        rd(4'd5, 32'd0, "uptime_hi_shadow");
        @(negedge clock);
        address = 4'd4;
        read    = 1'b1;
        @(negedge clock);
        read = 1'b0;
        chk("uptime_lo2_rdv", {31'b0, readdatavalid}, 32'd1);
        chk("uptime_lo2_small", {16'b0, readdata[31:16]}, 32'd0);
        rd(4'd5, 32'd1, "uptime_hi_after_carry");

        wr(4'd0, 32'hDEAD_BEEF, "write_ro_id");
        rd(4'd0, c_ID, "id_unchanged");
        rd(4'd6, 32'd1, "status_err_set");
        wr(4'd6, 32'd1, "status_clear");
        rd(4'd6, 32'd0, "status_cleared");
        rd(4'd7, 32'd0, "reserved_zero");
        rd(4'd12, 32'd0, "user_unmapped_zero");
        rd(4'd9, 32'h2222_0001, "user1");

        wr(4'd3, 32'h1357_9BDF, "write_scratch2");
        @(negedge clock);
        address   = 4'd3;
        writedata = 32'hFFFF_FFFF;
        read      = 1'b1;
        write     = 1'b1;
        @(negedge clock);
        read  = 1'b0;
        write = 1'b0;
        chk("collide_no_rdv", {31'b0, readdatavalid}, 32'd0);
        rd(4'd6, 32'd1, "collide_err");
        rd(4'd3, 32'h1357_9BDF, "collide_scratch_kept");

        wr(4'd6, 32'd1, "status_clear2");
        rd(4'd6, 32'd0, "status_cleared2");
        @(negedge clock);
        address   = 4'd6;
        writedata = 32'd1;
        read      = 1'b1;
        write     = 1'b1;
        @(negedge clock);
        read  = 1'b0;
        write = 1'b0;
        chk("collide_status_no_rdv", {31'b0, readdatavalid}, 32'd0);
        rd(4'd6, 32'd1, "collide_set_wins");

        for (int k = 0; k < 16; k++) begin
            @(negedge clock);
            if (k > 0) begin
                chk($sformatf("burst_rdv_%0d", k - 1), {31'b0, readdatavalid}, 32'd1);
                if (k - 1 == 4)
                    chk("burst_lo_small", {16'b0, readdata[31:16]}, 32'd0);
                else
                    chk($sformatf("burst_data_%0d", k - 1), readdata, exp_map(k - 1));
            end
            address = 4'(k);
            read    = 1'b1;
        end
        @(negedge clock);
        read = 1'b0;
        chk("burst_rdv_15", {31'b0, readdatavalid}, 32'd1);
        chk("burst_data_15", readdata, exp_map(15));
        @(negedge clock);
        chk("burst_end_no_rdv", {31'b0, readdatavalid}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_limbus_sysid_ext
`default_nettype wire
